// File: rtl/fht_pkg.sv
// Shared types and helpers for the FHT stage/address sequencer.
package fht_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } fht_state_t;

   localparam int BUT_LAT = 2;

   // Ceiling log2, never less than 1 so it can size a bus directly.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/fht_dly.sv
// WIDTH x DEPTH register delay line with async reset and synchronous clear.
module fht_dly #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] pipe_r [DEPTH];

   // Shift register; clear empties every stage at once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) pipe_r[i] <= {WIDTH{1'b0}};
      end else if (clr) begin
         for (int i = 0; i < DEPTH; i++) pipe_r[i] <= {WIDTH{1'b0}};
      end else begin
         pipe_r[0] <= din;
         for (int i = 1; i < DEPTH; i++) pipe_r[i] <= pipe_r[i-1];
      end
   end

   assign dout = pipe_r[DEPTH-1];

endmodule

// File: rtl/fht_ctrl.sv
// Stage/address sequencer for the in-place radix-2 FHT engine.
// Optional abort input enabled by defining FHT_CTRL_ABORT_EN.
module fht_ctrl
   import fht_pkg::*;
#(
   parameter int N_LOG2 = 8,
   parameter int WR_LAT = BUT_LAT + 1
) (
   input  logic                      iCLK,
   input  logic                      iRESET,
   input  logic                      iSTART,
`ifdef FHT_CTRL_ABORT_EN
   input  logic                      iABORT,
`endif
   output logic                      oBUSY,
   output logic                      oDONE,
   output logic [clog2(N_LOG2)-1:0]  oSTAGE,
   output logic                      oBANK,
   output logic                      oRD_EN,
   output logic [N_LOG2-1:0]         oRD_ADDR_0,
   output logic [N_LOG2-1:0]         oRD_ADDR_1,
   output logic [N_LOG2-1:0]         oRD_ADDR_2,
   output logic [N_LOG2-2:0]         oROM_ADDR,
   output logic                      oWR_EN,
   output logic [N_LOG2-1:0]         oWR_ADDR_0,
   output logic [N_LOG2-1:0]         oWR_ADDR_1
);

   localparam int SW   = clog2(N_LOG2);
   localparam int KW   = N_LOG2 - 1;
   localparam int DW   = clog2(WR_LAT + 1);
   localparam int DLYW = 1 + 2 * N_LOG2;

   localparam logic [KW-1:0]     K_LAST = {KW{1'b1}};
   localparam logic [SW-1:0]     S_LAST = SW'(N_LOG2 - 1);
   localparam logic [SW-1:0]     ROM_SH = SW'(N_LOG2 - 1);
   localparam logic [DW-1:0]     D_LAST = DW'(WR_LAT - 1);
   localparam logic [N_LOG2-1:0] A_ONE  = N_LOG2'(1);

   fht_state_t        state_r;
   logic [KW-1:0]     k_r;
   logic [SW-1:0]     s_r;
   logic [DW-1:0]     d_r;
   logic              busy_r;
   logic              done_r;
   logic              rd_en_r;
   logic [N_LOG2-1:0] rd_addr_0_r;
   logic [N_LOG2-1:0] rd_addr_1_r;
   logic [N_LOG2-1:0] rd_addr_2_r;
   logic [N_LOG2-2:0] rom_addr_r;

   logic              abort_s;
   logic              clr_s;
   logic [KW-1:0]     gen_k_s;
   logic [SW-1:0]     gen_s_s;
   logic [N_LOG2-1:0] kx_s, h_s, mask_s, j_s, base_s;
   logic [N_LOG2-1:0] addr_0_s, addr_1_s, addr_2_s;
   logic [N_LOG2-2:0] rom_s;
   logic [DLYW-1:0]   dly_out_s;

`ifdef FHT_CTRL_ABORT_EN
   assign abort_s = iABORT;
`else
   assign abort_s = 1'b0;
`endif
   assign clr_s = abort_s && (state_r != IDLE);

   // Selects the (k, s) of the butterfly that the next edge will issue.
   always_comb begin
      gen_k_s = {KW{1'b0}};
      gen_s_s = {SW{1'b0}};
      case (state_r)
         RUN: begin
            gen_s_s = s_r;
            if (k_r != K_LAST) gen_k_s = k_r + KW'(1);
            else               gen_k_s = {KW{1'b0}};
         end
         DRAIN:   gen_s_s = s_r + SW'(1);
         default: gen_s_s = {SW{1'b0}};
      endcase
   end

   // Butterfly addresses: group base g*2H, offset j, mirrored partner for X2.
   always_comb begin
      kx_s     = {1'b0, gen_k_s};
      h_s      = A_ONE << gen_s_s;
      mask_s   = h_s - A_ONE;
      j_s      = kx_s & mask_s;
      base_s   = (kx_s & ~mask_s) << 1'b1;
      addr_0_s = base_s | j_s;
      addr_1_s = addr_0_s + h_s;
      addr_2_s = base_s + h_s + ((h_s - j_s) & mask_s);
      rom_s    = j_s[N_LOG2-2:0] << (ROM_SH - gen_s_s);
   end

   // Sequencer FSM with registered strobes and read addresses.
   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         state_r     <= IDLE;
         k_r         <= {KW{1'b0}};
         s_r         <= {SW{1'b0}};
         d_r         <= {DW{1'b0}};
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         rd_en_r     <= 1'b0;
         rd_addr_0_r <= {N_LOG2{1'b0}};
         rd_addr_1_r <= {N_LOG2{1'b0}};
         rd_addr_2_r <= {N_LOG2{1'b0}};
         rom_addr_r  <= {(N_LOG2-1){1'b0}};
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (iSTART && !abort_s) begin
                  state_r     <= RUN;
                  k_r         <= gen_k_s;
                  s_r         <= gen_s_s;
                  busy_r      <= 1'b1;
                  rd_en_r     <= 1'b1;
                  rd_addr_0_r <= addr_0_s;
                  rd_addr_1_r <= addr_1_s;
                  rd_addr_2_r <= addr_2_s;
                  rom_addr_r  <= rom_s;
               end
            end
            RUN: begin
               if (abort_s) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
                  rd_en_r <= 1'b0;
               end else if (k_r == K_LAST) begin
                  state_r <= DRAIN;
                  d_r     <= {DW{1'b0}};
                  rd_en_r <= 1'b0;
               end else begin
                  k_r         <= gen_k_s;
                  rd_addr_0_r <= addr_0_s;
                  rd_addr_1_r <= addr_1_s;
                  rd_addr_2_r <= addr_2_s;
                  rom_addr_r  <= rom_s;
               end
            end
            DRAIN: begin
               if (abort_s) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end else if (d_r != D_LAST) begin
                  d_r <= d_r + DW'(1);
               end else if (s_r == S_LAST) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end else begin
                  state_r     <= RUN;
                  k_r         <= gen_k_s;
                  s_r         <= gen_s_s;
                  rd_en_r     <= 1'b1;
                  rd_addr_0_r <= addr_0_s;
                  rd_addr_1_r <= addr_1_s;
                  rd_addr_2_r <= addr_2_s;
                  rom_addr_r  <= rom_s;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               rd_en_r <= 1'b0;
            end
         endcase
      end
   end

   // Write strobe and addresses follow the read by the full read+butterfly latency.
   fht_dly #(
      .WIDTH (DLYW),
      .DEPTH (WR_LAT)
   ) u_wr_dly (
      .clk     (iCLK),
      .reset_n (iRESET),
      .clr     (clr_s),
      .din     ({rd_en_r, rd_addr_0_r, rd_addr_1_r}),
      .dout    (dly_out_s)
   );

   assign oBUSY      = busy_r;
   assign oDONE      = done_r;
   assign oSTAGE     = s_r;
   assign oBANK      = s_r[0];
   assign oRD_EN     = rd_en_r;
   assign oRD_ADDR_0 = rd_addr_0_r;
   assign oRD_ADDR_1 = rd_addr_1_r;
   assign oRD_ADDR_2 = rd_addr_2_r;
   assign oROM_ADDR  = rom_addr_r;
   assign {oWR_EN, oWR_ADDR_0, oWR_ADDR_1} = dly_out_s;

endmodule

// File: doc/fht_ctrl.md
# fht_ctrl

Stage/address sequencer for the in-place radix-2 FHT engine. On a start request it walks all log2(N) stages and issues one butterfly per cycle: ping-pong RAM read addresses for the X0/X1/X2 operands, the twiddle ROM address for the sin/cos pair, and write-back addresses for Y0/Y1. Write-back addresses are delayed to match the RAM read plus the 2-cycle butterfly pipeline. It sits between the host start/done handshake and the data RAMs, twiddle ROM and butterfly datapath; the input is loaded in bit-reversed order before start.

## Interface
- N_LOG2, 8, log2 of transform length N (N = 2^N_LOG2, N_LOG2 >= 2)
- WR_LAT, 3, cycles from read issue to write strobe (1 RAM read + 2 butterfly)
- iCLK  in  1  clock
- iRESET  in  1  reset; iRESET, asynchronous, active-low; clock iCLK
- iSTART  in  1  start request, sampled only in IDLE
- oBUSY  out  1  high in RUN and DRAIN
- oDONE  out  1  one-cycle pulse after the final stage completes
- oSTAGE  out  log2(N_LOG2) rounded up  current stage index s
- oBANK  out  1  read bank = s[0]; write bank = ~oBANK
- oRD_EN  out  1  read strobe, one butterfly per cycle
- oRD_ADDR_0/1/2  out  N_LOG2 each  X0, X1, X2 read addresses
- oROM_ADDR  out  N_LOG2-1  twiddle ROM address (sin/cos pair)
- oWR_EN  out  1  write strobe for Y0/Y1
- oWR_ADDR_0/1  out  N_LOG2 each  Y0, Y1 write addresses

## Operation
- States:
  - IDLE: wait for iSTART.
  - RUN: issue N/2 butterflies, counter k = 0..N/2-1.
  - DRAIN: WR_LAT cycles, no reads.
  - After DRAIN: if s = N_LOG2-1, go to IDLE and pulse oDONE. Otherwise increment s, go to RUN, reset k.
- Address generation in stage s, with H = 2^s, L = 2H, g = k>>s, j = k & (H-1):
  - addr0 = g·L + j
  - addr1 = addr0 + H
  - addr2 = g·L + H + ((H−j) mod H), so j=0 gives addr2 = addr1
  - ROM = j << (N_LOG2−1−s)
- Write path: oWR_ADDR_0/1 = addr0/addr1 and oWR_EN = oRD_EN, each delayed exactly WR_LAT cycles.
- The drain guarantees every stage-s write lands before any stage-s+1 read, so the bank flip is safe without per-write bank tracking.
- iSTART outside IDLE is ignored. iSTART in the cycle oDONE is high is accepted.
- Reset value of all outputs is 0. Reset mid-transform abandons the transform asynchronously: the delay line is cleared, no oDONE.

## Timing
- iSTART sampled high at edge 0 (IDLE): first RUN cycle is 1, with k=0, oRD_EN=1, s=0.
- The read issued in cycle c has its oWR_EN in cycle c+WR_LAT.
- Per stage: N/2 RUN plus WR_LAT DRAIN cycles. oBUSY high for N_LOG2·(N/2+WR_LAT) cycles.
- oDONE is high in the first IDLE cycle after the last DRAIN cycle. The last write strobe occurs in the final DRAIN cycle.
- oRD_EN is low in DRAIN and IDLE. Addresses are don't-care when their strobe is low but held at last value.
- All outputs are registered: state, k, s and the delay line. No combinational input-to-output path.

## Configuration
- FHT_CTRL_ABORT_EN defined:
  - Adds input iABORT (1 bit). iABORT high in RUN or DRAIN forces IDLE at the next edge and synchronously clears the write delay line, so no further oWR_EN. No oDONE is produced.
  - iABORT together with iSTART in IDLE: abort wins, start is ignored.
- FHT_CTRL_ABORT_EN undefined: port absent, and a transform always runs to completion unless iRESET is asserted.

## Structure
- Shared package fht_pkg holds the state enum (IDLE/RUN/DRAIN) and the function clog2 used for stage-index width. Butterfly latency constant is BUT_LAT=2; WR_LAT defaults to BUT_LAT+1.
- Sub-module fht_dly: parameterised WIDTH×DEPTH register delay line with async reset and synchronous clear. Used for {wr_en, wr_addr_0, wr_addr_1}.

## Test plan
- N_LOG2=3, pulse iSTART -> oBUSY cycles 1..21 (3·(4+3)), oDONE only in cycle 22, exactly 12 oRD_EN and 12 oWR_EN pulses.
- N_LOG2=3, stage 1 -> (addr0, addr1, addr2, ROM) for k=0..3 are (0,2,2,0), (1,3,3,2), (4,6,6,0), (5,7,7,2). oBANK=1.
- N_LOG2=3, stage 2, k=1 -> (1,5,7,1). k=3 -> (3,7,5,3). Each write address equals the read address issued 3 cycles earlier.
- iSTART asserted in cycle 5 of RUN, and again in the oDONE cycle -> first ignored, second starts a new transform with RUN in the following cycle.
- iRESET low during stage 1 DRAIN -> all outputs 0 immediately. After release, IDLE with no oWR_EN and no oDONE until a new iSTART.
- FHT_CTRL_ABORT_EN, iABORT in stage 0 RUN at k=2 -> IDLE next edge, zero oWR_EN afterwards, no oDONE. Subsequent iSTART runs a full 21-cycle transform.
